pulse_pattern_detector: RTL and testbench

Receiver-side checker for the periodic pulse-train generators in the clocking guides. It samples a single-bit pulse signal on every rising clock edge and measures consecutive high and low run lengths. It flags each complete period of exactly HIGH_LEN highs followed by LOW_LEN lows, and reports malformed runs. It sits on a generator's output in a bench or on-chip self-check path.

---
 rtl/pulse_pattern_detector.sv | 131 +++++++++++++
 tb/tb_pulse_pattern_detector.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_pattern_detector.sv
// Pulse-train receiver check: measures consecutive high/low run lengths and
// flags each exact HIGH_LEN-high / LOW_LEN-low period, or any malformed run.
module pulse_pattern_detector #(
    parameter int HIGH_LEN = 4,
    parameter int LOW_LEN  = 4,
    parameter int CNT_W    = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             signal,
    output logic             match,
    output logic             error,
    output logic             locked,
    output logic [CNT_W-1:0] match_count
);

    localparam int MAX_LEN = (HIGH_LEN > LOW_LEN) ? HIGH_LEN : LOW_LEN;
    localparam int RUN_W   = $clog2(MAX_LEN + 1);

    localparam logic [RUN_W-1:0] HIGH_CNT  = RUN_W'(HIGH_LEN);
    localparam logic [RUN_W-1:0] LOW_CNT   = RUN_W'(LOW_LEN);
    localparam logic [RUN_W-1:0] RUN_ONE   = RUN_W'(1);
    localparam logic [CNT_W-1:0] COUNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [RUN_W-1:0] cnt, cnt_nx;
    logic             prev;
    logic             match_nx, error_nx, locked_nx;
    logic [CNT_W-1:0] count_nx;

    always_ff @(posedge clock) begin
        // NOTE: state uses non-blocking assignments so every register samples
        // the pre-edge values, independent of statement order.
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            prev        <= 1'b1;
            match       <= 1'b0;
            error       <= 1'b0;
            locked      <= 1'b0;
            match_count <= '0;
        end else begin
            state       <= state_nx;
            cnt         <= cnt_nx;
            prev        <= signal;
            match       <= match_nx;
            error       <= error_nx;
            locked      <= locked_nx;
            match_count <= count_nx;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        state_nx  = state;
        cnt_nx    = cnt;
        match_nx  = 1'b0;
        error_nx  = 1'b0;
        locked_nx = locked;
        count_nx  = match_count;

        case (state)
            IDLE: begin
                // Only a genuine rising edge starts a period.
                if (signal && !prev) begin
                    state_nx = HIGH;
                    cnt_nx   = RUN_ONE;
                end
            end

            HIGH: begin
                if (signal) begin
                    if (cnt < HIGH_CNT) begin
                        cnt_nx = cnt + RUN_ONE;
                    end else begin
                        error_nx  = 1'b1;
                        locked_nx = 1'b0;
                        state_nx  = IDLE;
                        cnt_nx    = '0;
                    end
                end else if (cnt == HIGH_CNT) begin
                    state_nx = LOW;
                    cnt_nx   = RUN_ONE;
                end else begin
                    error_nx  = 1'b1;
                    locked_nx = 1'b0;
                    state_nx  = IDLE;
                    cnt_nx    = '0;
                end
            end

            LOW: begin
                if (!signal) begin
                    if (cnt < LOW_CNT) begin
                        cnt_nx = cnt + RUN_ONE;
                    end else begin
                        error_nx  = 1'b1;
                        locked_nx = 1'b0;
                        state_nx  = IDLE;
                        cnt_nx    = '0;
                    end
                end else begin
                    // Either way this rising edge opens the next high run.
                    state_nx = HIGH;
                    cnt_nx   = RUN_ONE;
                    if (cnt == LOW_CNT) begin
                        match_nx  = 1'b1;
                        locked_nx = 1'b1;
                        count_nx  = match_count + COUNT_ONE;
                    end else begin
                        error_nx  = 1'b1;
                        locked_nx = 1'b0;
                    end
                end
            end

            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_pattern_detector.sv
// Directed bench for pulse_pattern_detector: three instances (default, CNT_W=2,
// HIGH_LEN=1/LOW_LEN=2) checked every cycle against a run-length model.
module tb_pulse_pattern_detector;

    logic       clock = 1'b0;
    logic       reset;
    logic       signal;

    logic       match1, error1, locked1;
    logic [7:0] count1;
    logic       match2, error2, locked2;
    logic [1:0] count2;
    logic       match3, error3, locked3;
    logic [7:0] count3;

    int checks = 0;
    int errors = 0;
    bit seen_reset = 1'b0;

    always #5 clock = ~clock;

    pulse_pattern_detector #(.HIGH_LEN(4), .LOW_LEN(4), .CNT_W(8)) dut1 (
        .clock(clock), .reset(reset), .signal(signal),
        .match(match1), .error(error1), .locked(locked1), .match_count(count1)
    );

    pulse_pattern_detector #(.HIGH_LEN(4), .LOW_LEN(4), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset), .signal(signal),
        .match(match2), .error(error2), .locked(locked2), .match_count(count2)
    );

    pulse_pattern_detector #(.HIGH_LEN(1), .LOW_LEN(2), .CNT_W(8)) dut3 (
        .clock(clock), .reset(reset), .signal(signal),
        .match(match3), .error(error3), .locked(locked3), .match_count(count3)
    );

    // Run-length model: tracks the value and length of the current run once a
    // rising edge has synchronised it, and judges each run when it ends.
    typedef struct {
        bit synced;
        bit run_val;
        int run_len;
        bit prev;
        bit match;
        bit error;
        bit locked;
        int count;
    } model_t;

    model_t m1, m2, m3;

    function automatic model_t model_step(model_t m, bit rst, bit s, int hl, int ll);
        model_t n;
        int need;
        n = m;
        n.match = 1'b0;
        n.error = 1'b0;
        if (rst) begin
            n.synced  = 1'b0;
            n.run_val = 1'b0;
            n.run_len = 0;
            n.prev    = 1'b1;
            n.locked  = 1'b0;
            n.count   = 0;
            return n;
        end
        need = m.run_val ? hl : ll;
        if (!m.synced) begin
            if (s && !m.prev) begin
                n.synced  = 1'b1;
                n.run_val = 1'b1;
                n.run_len = 1;
            end
        end else if (s == m.run_val) begin
            n.run_len = m.run_len + 1;
            if (n.run_len > need) begin
                n.error  = 1'b1;
                n.locked = 1'b0;
                n.synced = 1'b0;
            end
        end else begin
            n.run_val = s;
            n.run_len = 1;
            if (m.run_len != need) begin
                n.error  = 1'b1;
                n.locked = 1'b0;
                n.synced = s;        // a short low still resyncs on its rising edge
            end else if (s) begin
                n.match  = 1'b1;
                n.locked = 1'b1;
                n.count  = m.count + 1;
            end
        end
        n.prev = s;
        return n;
    endfunction

    always @(posedge clock) begin
        m1 = model_step(m1, reset, signal, 4, 4);
        m2 = model_step(m2, reset, signal, 4, 4);
        m3 = model_step(m3, reset, signal, 1, 2);
        if (reset) seen_reset = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (seen_reset) begin
            check("d1.match",  int'(match1),  int'(m1.match));
            check("d1.error",  int'(error1),  int'(m1.error));
            check("d1.locked", int'(locked1), int'(m1.locked));
            check("d1.count",  int'(count1),  m1.count % 256);
            check("d2.match",  int'(match2),  int'(m2.match));
            check("d2.error",  int'(error2),  int'(m2.error));
            check("d2.locked", int'(locked2), int'(m2.locked));
            check("d2.count",  int'(count2),  m2.count % 4);
            check("d3.match",  int'(match3),  int'(m3.match));
            check("d3.error",  int'(error3),  int'(m3.error));
            check("d3.locked", int'(locked3), int'(m3.locked));
            check("d3.count",  int'(count3),  m3.count % 256);
        end
    end

    task automatic cycle(input bit r, input bit s);
        reset  = r;
        signal = s;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic hold(input bit s, input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, s);
    endtask

    task automatic period();
        hold(1'b1, 4);
        hold(1'b0, 4);
    endtask

    int exp_seq[5] = '{1, 2, 3, 0, 1};

    initial begin
        // Defaults: reset, idle low, three clean periods, closing rising edge.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);
        check("reset.count",  int'(count1),  0);
        check("reset.locked", int'(locked1), 0);
        check("reset.match",  int'(match1),  0);
        hold(1'b0, 3);
        period();
        period();
        period();
        cycle(1'b0, 1'b1);
        check("defaults.match",  int'(match1),  1);
        check("defaults.count",  int'(count1),  3);
        check("defaults.locked", int'(locked1), 1);

        // Short high: three highs then a low.
        hold(1'b1, 2);
        cycle(1'b0, 1'b0);
        check("short_high.error",  int'(error1),  1);
        check("short_high.locked", int'(locked1), 0);
        check("short_high.count",  int'(count1),  3);
        hold(1'b0, 4);
        period();
        cycle(1'b0, 1'b1);
        check("short_high.recover", int'(count1), 4);

        // Long high: fifth consecutive high is the violation.
        hold(1'b1, 4);
        check("long_high.error", int'(error1), 1);
        hold(1'b1, 3);
        check("long_high.no_match", int'(count1), 4);
        cycle(1'b0, 1'b0);
        period();
        cycle(1'b0, 1'b1);
        check("long_high.recover", int'(count1), 5);

        // Short low: the early rising edge is the resync point.
        hold(1'b1, 3);
        hold(1'b0, 3);
        cycle(1'b0, 1'b1);
        check("short_low.error",  int'(error1),  1);
        check("short_low.locked", int'(locked1), 0);
        hold(1'b1, 3);
        hold(1'b0, 4);
        cycle(1'b0, 1'b1);
        check("short_low.match",  int'(match1),  1);
        check("short_low.count",  int'(count1),  6);
        check("short_low.locked", int'(locked1), 1);

        // Reset on the second high sample, then signal held high.
        cycle(1'b1, 1'b1);
        check("mid_reset.count",  int'(count1),  0);
        check("mid_reset.locked", int'(locked1), 0);
        check("mid_reset.match",  int'(match1),  0);
        check("mid_reset.error",  int'(error1),  0);
        hold(1'b1, 6);
        check("mid_reset.held_high", int'(count1), 0);
        cycle(1'b0, 1'b0);
        period();
        cycle(1'b0, 1'b1);
        check("mid_reset.recover", int'(count1), 1);

        // CNT_W=2 wrap across five clean periods.
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        for (int p = 0; p < 5; p++) begin
            cycle(1'b0, 1'b1);
            if (p > 0) begin
                check("wrap.count",  int'(count2),  exp_seq[p-1]);
                check("wrap.locked", int'(locked2), 1);
            end
            hold(1'b1, 3);
            hold(1'b0, 4);
        end
        cycle(1'b0, 1'b1);
        check("wrap.count_last", int'(count2),  exp_seq[4]);
        check("wrap.locked",     int'(locked2), 1);

        // Single-sample high runs (HIGH_LEN=1, LOW_LEN=2).
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b1);
            hold(1'b0, 2);
        end
        cycle(1'b0, 1'b1);
        check("len1.count",  int'(count3),  3);
        check("len1.locked", int'(locked3), 1);
        cycle(1'b0, 1'b1);
        check("len1.long_high", int'(error3), 1);
        hold(1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
